// File: rtl/prog_loader_pkg.sv
// Shared state encoding and default parameter values for the program loader.
package prog_loader_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/prog_loader_cnt.sv
// Saturating run-cycle counter with terminal-count compare against a limit.
module prog_loader_cnt #(
    parameter int CNT_W = prog_loader_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             hit
);
    logic [CNT_W:0] count_inc;

    // One bit wider so the compare cannot alias when count is all-ones.
    assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
    assign hit       = en && (limit != '0) && (count_inc == {1'b0, limit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count_inc[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Streams a program image into external memory, releases the core and
// supervises it until HALT or a run-cycle limit.
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | accepting image words, writing memory
//   RUN     | core released, counting cycles
//   FIN     | core stopped, status held until next start
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              start,
    input  logic [CNT_W-1:0]  timeout_lim,
    input  logic              core_halted,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_run,
    output logic [ADDR_W-1:0] pc_init,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [CNT_W-1:0]  run_cycles
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  lim_q;
    logic              accept;
    logic              go;
    logic              hit;

    assign accept    = (state == ST_LOAD) && s_valid;
    assign go        = start && ((state == ST_IDLE) || (state == ST_FIN));
    assign s_ready   = (state == ST_LOAD);
    assign core_run  = (state == ST_RUN);
    assign mem_we    = accept;
    assign mem_addr  = ptr;
    assign mem_wdata = accept ? s_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FIN: if (start) state_nxt = ST_LOAD;
            ST_LOAD:         if (accept && s_last) state_nxt = ST_RUN;
            ST_RUN:          if (core_halted || hit) state_nxt = ST_FIN;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            pc_init  <= '0;
            lim_q    <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
        end else if (go) begin
            ptr      <= base_addr;
            pc_init  <= base_addr;
            lim_q    <= timeout_lim;
            done     <= 1'b0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            ptr <= ptr + 1'b1;
            if (ptr == {ADDR_W{1'b1}}) overflow <= 1'b1;
        end else if (state == ST_RUN) begin
            // HALT wins over a limit hit in the same cycle.
            if (core_halted) done <= 1'b1;
            else if (hit)    timeout <= 1'b1;
        end
    end

    prog_loader_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (go),
        .en    (state == ST_RUN),
        .limit (lim_q),
        .count (run_cycles),
        .hit   (hit)
    );
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as
// words are offered and popped when the DUT strobes mem_we.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_last, start, core_halted;
    logic [31:0] s_data, mem_wdata;
    logic [7:0]  base_addr, mem_addr, pc_init;
    logic [15:0] timeout_lim, run_cycles;
    logic        mem_we, core_run, done, timeout, overflow;

    logic [39:0] sb[$];
    logic [7:0]  exp_ptr;
    int          n_checks = 0;
    int          n_pass   = 0;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .base_addr(base_addr), .start(start),
        .timeout_lim(timeout_lim), .core_halted(core_halted), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_run(core_run),
        .pc_init(pc_init), .done(done), .timeout(timeout), .overflow(overflow),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            logic [39:0] exp_w;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({mem_addr, mem_wdata} !== exp_w)
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, exp_w[39:32], exp_w[31:0]);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] base, input logic [15:0] lim);
        base_addr = base; timeout_lim = lim; start = 1'b1;
        step;
        start = 1'b0;
        exp_ptr = base;
        n_checks++;
        if ({s_ready, done, timeout, overflow, run_cycles, pc_init} !== {4'b1000, 16'd0, base})
            $display("FAIL start_state: got rdy=%b dn=%b to=%b ov=%b rc=%0d pc=%0d, required 1 0 0 0 0 %0d",
                     s_ready, done, timeout, overflow, run_cycles, pc_init, base);
        else n_pass++;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input int gap);
        s_valid = 1'b1; s_data = d; s_last = last;
        sb.push_back({exp_ptr, d});
        exp_ptr = exp_ptr + 8'd1;
        step;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (gap) step;
    endtask

    task automatic check_sb_empty(input string name);
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s_missing_writes: got %0d pending, required 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_valid = 0; s_last = 0; s_data = '0; start = 0;
        core_halted = 0; base_addr = '0; timeout_lim = '0;
        #2;
        n_checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, core_run, pc_init, done, timeout, overflow, run_cycles} !== '0)
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d run=%b pc=%0d rc=%0d, required all 0",
                     s_ready, mem_we, mem_addr, core_run, pc_init, run_cycles);
        else n_pass++;
        step; step;
        rst_n = 1'b1;
        s_valid = 1'b1;
        step; step;
        s_valid = 1'b0;
        n_checks++;
        if ({s_ready, core_run} !== 2'b00) $display("FAIL idle_outputs: got rdy=%b run=%b, required 0 0", s_ready, core_run);
        else n_pass++;
    endtask

    task automatic test_load;
        logic [31:0] img[8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        start_load(8'd0, 16'd100);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (core_run !== 1'b0) $display("FAIL load_core_run_early: got %b, required 0 (word %0d)", core_run, i);
            else n_pass++;
            send_word(img[i], i == 7, 0);
        end
        check_sb_empty("load");
        n_checks++;
        if ({core_run, s_ready, pc_init} !== {2'b10, 8'd0})
            $display("FAIL load_enter_run: got run=%b rdy=%b pc=%0d, required 1 0 0", core_run, s_ready, pc_init);
        else n_pass++;
    endtask

    task automatic test_done;
        repeat (39) step;
        n_checks++;
        if ({core_run, done, run_cycles} !== {2'b10, 16'd39})
            $display("FAIL run_midway: got run=%b done=%b rc=%0d, required 1 0 39", core_run, done, run_cycles);
        else n_pass++;
        core_halted = 1'b1;
        step;
        core_halted = 1'b0;
        repeat (3) step;
        n_checks++;
        if ({done, timeout, run_cycles, core_run} !== {2'b10, 16'd40, 1'b0})
            $display("FAIL halt_done: got done=%b to=%b rc=%0d run=%b, required 1 0 40 0", done, timeout, run_cycles, core_run);
        else n_pass++;
    endtask

    task automatic test_timeout;
        start_load(8'd16, 16'd10);
        send_word(32'hdeadbeef, 1'b0, 0);
        send_word(32'h12345678, 1'b1, 0);
        check_sb_empty("timeout_load");
        repeat (9) step;
        n_checks++;
        if ({timeout, core_run} !== 2'b01) $display("FAIL timeout_early: got to=%b run=%b, required 0 1", timeout, core_run);
        else n_pass++;
        step;
        n_checks++;
        if ({timeout, done, run_cycles, core_run} !== {2'b10, 16'd10, 1'b0})
            $display("FAIL timeout_hit: got to=%b done=%b rc=%0d run=%b, required 1 0 10 0", timeout, done, run_cycles, core_run);
        else n_pass++;
    endtask

    task automatic test_wrap;
        start_load(8'd254, 16'd0);
        send_word(32'ha0000001, 1'b0, 0);
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL wrap_early: got ov=%b, required 0", overflow);
        else n_pass++;
        send_word(32'ha0000002, 1'b0, 0);
        send_word(32'ha0000003, 1'b0, 0);
        send_word(32'ha0000004, 1'b1, 0);
        check_sb_empty("wrap");
        repeat (20) step;
        n_checks++;
        if ({overflow, timeout, core_run, pc_init} !== {3'b101, 8'd254})
            $display("FAIL wrap_status: got ov=%b to=%b run=%b pc=%0d, required 1 0 1 254", overflow, timeout, core_run, pc_init);
        else n_pass++;
        core_halted = 1'b1;
        step;
        core_halted = 1'b0;
    endtask

    task automatic test_gaps;
        start_load(8'd100, 16'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                base_addr = 8'd200; start = 1'b1;
            end
            send_word(32'hc0de0000 + i, i == 4, (i == 4) ? 0 : 3);
            start = 1'b0;
        end
        check_sb_empty("gaps");
        n_checks++;
        if ({pc_init, core_run, overflow} !== {8'd100, 2'b10})
            $display("FAIL gaps_status: got pc=%0d run=%b ov=%b, required 100 1 0", pc_init, core_run, overflow);
        else n_pass++;
        core_halted = 1'b1;
        step;
        core_halted = 1'b0;
    endtask

    task automatic test_reset_run;
        start_load(8'h40, 16'd0);
        send_word(32'h11111111, 1'b0, 0);
        send_word(32'h22222222, 1'b1, 0);
        repeat (4) step;
        n_checks++;
        if (run_cycles !== 16'd4) $display("FAIL prereset_count: got %0d, required 4", run_cycles);
        else n_pass++;
        s_valid = 1'b1; s_data = 32'hbad0bad0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, core_run, pc_init, done, timeout, overflow, run_cycles} !== '0)
            $display("FAIL reset_in_run: got rdy=%b we=%b addr=%0d run=%b pc=%0d rc=%0d, required all 0",
                     s_ready, mem_we, mem_addr, core_run, pc_init, run_cycles);
        else n_pass++;
        s_valid = 1'b0; s_data = '0;
        step;
        rst_n = 1'b1;
        step;
        start_load(8'd8, 16'd0);
        send_word(32'h33333333, 1'b0, 0);
        send_word(32'h44444444, 1'b0, 1);
        send_word(32'h55555555, 1'b1, 0);
        check_sb_empty("reload");
        core_halted = 1'b1;
        step;
        core_halted = 1'b0;
        n_checks++;
        if ({done, run_cycles, pc_init} !== {1'b1, 16'd1, 8'd8})
            $display("FAIL reload_done: got done=%b rc=%0d pc=%0d, required 1 1 8", done, run_cycles, pc_init);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_load;
        test_done;
        test_timeout;
        test_wrap;
        test_gaps;
        test_reset_run;
        repeat (3) step;
        check_sb_empty("final");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_W, default 32, instruction/data word width.
REQ-002 Parameter ADDR_W, default 8, memory word-address width (depth 2**ADDR_W).
REQ-003 Parameter CNT_W, default 16, run-cycle counter width.
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  load word offered.
REQ-007 s_ready  out  1  loader accepts word.
REQ-008 s_data  in  DATA_W  word to store.
REQ-009 s_last  in  1  marks final word of image.
REQ-010 base_addr  in  ADDR_W  first memory address of image, sampled in IDLE on start.
REQ-011 start  in  1  one-cycle pulse to begin load.
REQ-012 timeout_lim  in  CNT_W  max run cycles, sampled with base_addr; 0 disables timeout.
REQ-013 core_halted  in  1  core HALT flag.
REQ-014 mem_we  out  1  memory write strobe.
REQ-015 mem_addr  out  ADDR_W  memory write address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 core_run  out  1  releases core (high = run, PC set to base_addr by core).
REQ-018 pc_init  out  ADDR_W  start PC for core, equal to sampled base_addr.
REQ-019 done  out  1  core halted within limit; sticky until next start.
REQ-020 timeout  out  1  limit reached before halt; sticky until next start.
REQ-021 overflow  out  1  image wrapped past top address; sticky until next start.
REQ-022 run_cycles  out  CNT_W  cycles spent in RUN, saturating.

Function
REQ-023 States IDLE, LOAD, RUN, FIN; one-hot or binary encoding free.
REQ-024 IDLE: s_ready=0, core_run=0; start=1 -> sample base_addr/timeout_lim, clear done/timeout/overflow/run_cycles, write pointer=base_addr, go LOAD.
REQ-025 LOAD: s_ready=1; word accepted when s_valid&s_ready; on accept mem_we=1, mem_addr=pointer, mem_wdata=s_data in the same cycle (combinational, zero latency); pointer increments by 1 modulo 2**ADDR_W.
REQ-026 Pointer wrap from 2**ADDR_W-1 to 0 sets overflow; loading continues.
REQ-027 Accept with s_last=1 -> go RUN next cycle; no further words accepted.
REQ-028 s_valid=0 in LOAD: stall, no write, no timeout counting.
REQ-029 RUN: core_run=1, s_ready=0, mem_we=0; run_cycles increments each cycle, saturates at all-ones.
REQ-030 RUN exit: core_halted=1 -> done=1, go FIN; else if timeout_lim!=0 and run_cycles+1==timeout_lim -> timeout=1, go FIN; core_halted has priority on the same cycle.
REQ-031 FIN: core_run=0; status held; start=1 -> behaves as REQ-024 (restart directly to LOAD).
REQ-032 start outside IDLE/FIN ignored.
REQ-033 pc_init constant from sampling until next start.

Reset
REQ-034 rst_n low -> state IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata don't-care-driven 0, core_run=0, pc_init=0, done=0, timeout=0, overflow=0, run_cycles=0, immediately (asynchronously).
REQ-035 Reset mid-LOAD or mid-RUN abandons operation; no write in reset cycle; outputs as REQ-034.

Structure
REQ-036 State encoding and default parameter constants in shared package prog_loader_pkg.
REQ-037 One sub-module natural: prog_loader_cnt (saturating run counter with limit compare).
REQ-038 No memory inside block; it drives an external single-port memory.

Verification
REQ-039 base=0, 8 words 28010078,0c631800,20220000,0c631800,2842002d,0c631800,24220001,fc000000, last on 8th -> writes addr 0..7 in order, core_run rises cycle after 8th accept.
REQ-040 RUN, core_halted raised after 40 cycles, limit 100 -> done=1, timeout=0, run_cycles=40, core_run=0.
REQ-041 limit 10, core_halted never -> timeout=1 after 10 RUN cycles, run_cycles=10.
REQ-042 ADDR_W=8, base=254, 4 words -> addresses 254,255,0,1; overflow=1.
REQ-043 s_valid gaps of 3 cycles between words -> no extra writes, addresses contiguous.
REQ-044 rst_n low during RUN cycle 5 -> all outputs at reset values same cycle; later start reloads normally.
